// File: rtl/booth_mult_arbiter_if.sv
// Client-side bus of the shared Booth multiplier arbiter.
// Request holds req[i] high with stable operands until ack[i]; ack is a 1-cycle pulse, resp_valid a 1-cycle pulse.
interface booth_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_m;
    logic [NUM_REQ*WIDTH-1:0] req_q;
    logic [NUM_REQ-1:0]       ack;
    logic                     resp_valid;
    logic [IDW-1:0]           resp_id;
    logic [2*WIDTH-1:0]       resp_p;

    modport master (
        output req, req_m, req_q,
        input  ack, resp_valid, resp_id, resp_p
    );

    modport slave (
        input  req, req_m, req_q,
        output ack, resp_valid, resp_id, resp_p
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one sequential Booth multiplier among NUM_REQ clients.
// Sequences multiplier reset/load, waits MULT_CYCLES, returns the product tagged with the client index.
module booth_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 4,
    parameter int MULT_CYCLES = 4,
    parameter int IDW         = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_mult_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 mult_reset,
    output logic                 mult_load,
    output logic [WIDTH-1:0]     mult_m,
    output logic [WIDTH-1:0]     mult_q,
    input  logic [2*WIDTH-1:0]   mult_p,
    output logic [2:0]           dbg_state
);
    localparam int CW = $clog2(MULT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  cnt;
    logic           found;
    logic [IDW-1:0] grant;

    assign dbg_state = state;

    // Scan starts at rr_ptr and wraps, so the most recent winner is considered last.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            cnt            <= '0;
            bus.ack        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_p     <= '0;
            busy           <= 1'b0;
            mult_reset     <= 1'b1;
            mult_load      <= 1'b0;
            mult_m         <= '0;
            mult_q         <= '0;
        end else begin
            bus.ack        <= '0;
            bus.resp_valid <= 1'b0;
            mult_load      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mult_m      <= bus.req_m[grant*WIDTH +: WIDTH];
                        mult_q      <= bus.req_q[grant*WIDTH +: WIDTH];
                        bus.resp_id <= grant;
                        bus.ack     <= NUM_REQ'(1) << grant;
                        rr_ptr      <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
                        mult_reset  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    mult_reset <= 1'b0;
                    mult_load  <= 1'b1;
                    state      <= S_LOAD;
                end
                S_LOAD: begin
                    cnt   <= CW'(MULT_CYCLES - 1);
                    state <= S_RUN;
                end
                S_RUN: begin
                    // mult_p is final during the last RUN cycle; capture it on the way out.
                    if (cnt == '0) begin
                        bus.resp_p     <= mult_p;
                        bus.resp_valid <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: Booth multiplier datapath, phase-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_booth_mult_arbiter;
    localparam int N    = 4;
    localparam int W    = 4;
    localparam int MC   = 4;
    localparam int IDW  = 2;
    localparam int LAST = MC + 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    booth_mult_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) bus ();

    logic           busy, mult_reset, mult_load;
    logic [W-1:0]   mult_m, mult_q;
    logic [2*W-1:0] mult_p;
    logic [2:0]     dbg_state;

    booth_mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .MULT_CYCLES(MC), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .mult_reset (mult_reset),
        .mult_load  (mult_load),
        .mult_m     (mult_m),
        .mult_q     (mult_q),
        .mult_p     (mult_p),
        .dbg_state  (dbg_state)
    );

    // Booth radix-2 multiplier; the load edge also performs the first iteration.
    logic signed [W:0] bm_a;
    logic [W-1:0]      bm_q, bm_m;
    logic              bm_q1;
    int                bm_cnt;

    always @(posedge clk) begin : booth_model
        logic signed [W:0] a, mx;
        logic [W-1:0] q;
        logic q1;
        int c;
        a = bm_a; q = bm_q; q1 = bm_q1; c = bm_cnt; mx = {bm_m[W-1], bm_m};
        if (mult_reset) begin
            a = '0; q = '0; q1 = 1'b0; c = 0; mx = '0;
        end else begin
            if (mult_load) begin
                a = '0; q = mult_q; q1 = 1'b0; mx = {mult_m[W-1], mult_m}; c = W;
            end
            if (c > 0) begin
                case ({q[0], q1})
                    2'b01:   a = a + mx;
                    2'b10:   a = a - mx;
                    default: ;
                endcase
                q1 = q[0];
                q  = {a[0], q[W-1:1]};
                a  = {a[W], a[W:1]};
                c  = c - 1;
            end
        end
        bm_a <= a; bm_q <= q; bm_q1 <= q1; bm_cnt <= c; bm_m <= mx[W-1:0];
    end
    assign mult_p = {bm_a[W-1:0], bm_q};

    // Reference model: phase 0 idle, phase p = p-th cycle after the grant edge.
    int             ph = 0;
    int             rr = 0;
    int             g = 0;
    logic [W-1:0]   m_m = '0, m_q = '0;
    logic [2*W-1:0] e_p = '0;
    logic [IDW-1:0] e_id = '0;
    logic           e_mrst = 1'b1;

    always @(posedge clk) begin : ref_model
        bit hit;
        int j, mi, qi;
        if (!reset) begin
            ph = 0; rr = 0; g = 0; m_m = '0; m_q = '0; e_p = '0; e_id = '0; e_mrst = 1'b1;
        end else if (ph == 0) begin
            if (bus.req != '0) begin
                hit = 1'b0;
                for (int i = 0; i < N; i++) begin
                    j = (rr + i) % N;
                    if (!hit && bus.req[j]) begin
                        hit = 1'b1;
                        g = j;
                    end
                end
                m_m = bus.req_m[g*W +: W];
                m_q = bus.req_q[g*W +: W];
                e_id = IDW'(g);
                rr = (g + 1) % N;
                e_mrst = 1'b1;
                ph = 1;
            end
        end else begin
            ph = (ph == LAST) ? 0 : ph + 1;
            if (ph == 2) e_mrst = 1'b0;
            if (ph == LAST) begin
                mi = $signed(m_m);
                qi = $signed(m_q);
                e_p = (2*W)'(mi * qi);
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int resp_seen = 0;
    logic [N-1:0] hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: requesters drop req in their ack cycle, then outputs are compared to the model.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (bus.ack[i] && !hold[i]) bus.req[i] = 1'b0;
        if (bus.ack != '0) ack_cyc = cyc;
        if (bus.resp_valid) resp_seen++;
        @(negedge clk);
        check("m_ack",        bus.ack,        (ph == 1) ? (32'd1 << g) : 32'd0);
        check("m_resp_valid", bus.resp_valid, (ph == LAST) ? 32'd1 : 32'd0);
        check("m_resp_id",    bus.resp_id,    e_id);
        check("m_resp_p",     bus.resp_p,     e_p);
        check("m_busy",       busy,           (ph != 0) ? 32'd1 : 32'd0);
        check("m_mult_reset", mult_reset,     e_mrst);
        check("m_mult_load",  mult_load,      (ph == 2) ? 32'd1 : 32'd0);
        check("m_mult_m",     mult_m,         m_m);
        check("m_mult_q",     mult_q,         m_q);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
        bus.req_m[i*W +: W] = m;
        bus.req_q[i*W +: W] = q;
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int idx);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (bus.ack == '0 && n < 60);
        check("ack_grant", bus.ack, 32'd1 << idx);
    endtask

    task automatic wait_resp(input int id, input logic [2*W-1:0] p);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!bus.resp_valid && n < 60);
        check("resp_valid", bus.resp_valid, 1);
        check("resp_id", bus.resp_id, id);
        check("resp_p", bus.resp_p, p);
        check("resp_latency", cyc - ack_cyc, 6);
    endtask

    task automatic drain();
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((busy || bus.req != '0) && n < 200);
        check("drain_idle", busy, 0);
    endtask

    initial begin
        bus.req = '0;
        bus.req_m = '0;
        bus.req_q = '0;
        reset = 1'b0;
        repeat (3) cycle();
        check("rst_busy", busy, 0);
        check("rst_mult_reset", mult_reset, 1);
        check("rst_resp_p", bus.resp_p, 0);
        check("rst_ack", bus.ack, 0);
        reset = 1'b1;
        cycle();

        // Single operations: 5*3, -5*3, -6*-5, -8*-8
        set_op(0, 4'b0101, 4'b0011);
        wait_ack(0);
        cycle();
        check("load_pulse", mult_load, 1);
        check("load_m", mult_m, 4'b0101);
        check("load_q", mult_q, 4'b0011);
        wait_resp(0, 8'h0F);
        set_op(1, 4'b1011, 4'b0011);
        wait_ack(1);
        wait_resp(1, 8'hF1);
        set_op(2, 4'b1010, 4'b1011);
        wait_ack(2);
        wait_resp(2, 8'h1E);
        set_op(3, 4'b1000, 4'b1000);
        wait_ack(3);
        wait_resp(3, 8'h40);
        drain();

        // Round robin: all four from reset, then 0 and 3 raised together after grant 2
        reset = 1'b0;
        cycle();
        for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 4'b0010);
        reset = 1'b1;
        wait_ack(0);
        wait_ack(1);
        wait_ack(2);
        wait_ack(3);
        set_op(1, 4'b0001, 4'b0001);
        set_op(2, 4'b0001, 4'b0001);
        wait_ack(1);
        wait_ack(2);
        set_op(0, 4'b0010, 4'b0010);
        set_op(3, 4'b0011, 4'b0011);
        wait_ack(3);
        wait_ack(0);
        wait_resp(0, 8'h04);
        drain();

        // Reset pulse during RUN drops the operation
        set_op(1, 4'b0111, 4'b0111);
        wait_ack(1);
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check("abort_busy", busy, 0);
        check("abort_mult_reset", mult_reset, 1);
        check("abort_resp_valid", bus.resp_valid, 0);
        reset = 1'b1;
        resp_seen = 0;
        repeat (10) cycle();
        check("abort_no_resp", resp_seen, 0);
        set_op(2, 4'b0010, 4'b1101);
        wait_ack(2);
        wait_resp(2, 8'hFA);
        drain();

        // Operands latched at grant; a held request waits behind the other requesters
        set_op(0, 4'b0111, 4'b0010);
        wait_ack(0);
        repeat (3) cycle();
        bus.req_m[0 +: W] = 4'b1111;
        bus.req_q[0 +: W] = 4'b0101;
        wait_resp(0, 8'h0E);
        hold[1] = 1'b1;
        set_op(1, 4'b0011, 4'b0011);
        wait_ack(1);
        set_op(2, 4'b0100, 4'b0011);
        set_op(3, 4'b1111, 4'b0110);
        wait_ack(2);
        wait_ack(3);
        hold[1] = 1'b0;
        wait_ack(1);
        wait_resp(1, 8'h09);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
